jk_cmd_conditioner: RTL and testbench
=====================================

# jk_cmd_conditioner

- Input-side conditioner that sits directly upstream of the JK flip-flop.
- Takes two raw, asynchronous push-button inputs (set, clear) and synchronises and debounces each one.
- Turns each debounced rising edge into a single-cycle `j` / `k` command pulse for the flip-flop.
- Includes a short pairing window: two presses that land close together become one simultaneous `j=k=1` (toggle) command instead of two separate commands.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronised input must differ from its debounced level before that level changes; ≥1.
- `CNT_W`, default 3: width of each debounce counter; requires 2^CNT_W > DEBOUNCE_CYCLES.
- `PAIR_WINDOW`, default 2: cycles a lone rising edge waits for the other channel; ≥1; requires PAIR_WINDOW < 2*DEBOUNCE_CYCLES.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; low clears all state immediately.
- `btn_set`  in  1  raw set request, asynchronous to `clk`.
- `btn_clr`  in  1  raw clear request, asynchronous to `clk`.
- `j`  out  1  registered one-cycle command pulse to the flip-flop J input.
- `k`  out  1  registered one-cycle command pulse to the flip-flop K input.
- `set_level`  out  1  debounced level of `btn_set`.
- `clr_level`  out  1  debounced level of `btn_clr`.

## Operation

- **Synchroniser**, per channel: 2-flop chain raw → s1 → s2, reset value 0.
- **Debouncer**, per channel: holds `lvl` and `cnt`, both reset to 0.
  - If s2 == lvl: cnt ← 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: lvl ← s2, cnt ← 0.
  - Else: cnt ← cnt+1.
  - Any return of s2 to lvl before expiry restarts the count.
- **Rise detect**, per channel: rise = lvl & ~lvl_d, where lvl_d is lvl registered, reset 0. Falling edges generate no command.
- **FSM**: states IDLE, PEND_J, PEND_K; window counter `win` (reset 0); reset state IDLE.
  - IDLE, both rises: pulse j=k=1; stay IDLE.
  - IDLE, set rise only: → PEND_J, win ← 0.
  - IDLE, clr rise only: → PEND_K, win ← 0.
  - PEND_J, clr rise: pulse j=k=1; → IDLE.
  - PEND_J, else if win == PAIR_WINDOW-1: pulse j only; → IDLE.
  - PEND_J, otherwise: win ← win+1.
  - PEND_K: mirror of PEND_J, with the lone pulse on k.
  - A same-channel rise while pending cannot occur under the parameter constraints; if it does, it is ignored.
- **Outputs**:
  - `j` and `k` are registered and high for exactly one cycle per command; otherwise 0.
  - `set_level` = set lvl and `clr_level` = clr lvl.
- **Reset mid-operation**:
  - All outputs go to 0 asynchronously.
  - Any pending command is discarded, with no pulse.
  - A button still held at reset release re-debounces from lvl=0 and produces a fresh command.

## Timing

Edges are numbered from the first `clk` rising edge that samples a new raw level.
- s1 updates at edge 1; s2 at edge 2; lvl at edge 2+DEBOUNCE_CYCLES.
- The FSM acts on the rise at edge 3+DEBOUNCE_CYCLES.
- Simultaneous presses: `j`/`k` high in the cycle after edge 3+DEBOUNCE_CYCLES.
- Lone press: pulse high in the cycle after edge 3+DEBOUNCE_CYCLES+PAIR_WINDOW. Defaults: after edge 9.
- Paired press: pulse high in the cycle after the edge at which the second channel's rise is acted on.
- Minimum glitch rejected: any excursion of s2 shorter than DEBOUNCE_CYCLES cycles.
- No combinational path from any input to any output.

## Test plan

All scenarios use default parameters (DEBOUNCE_CYCLES=4, PAIR_WINDOW=2).
1. `reset`=0 with buttons toggling → j=k=0, set_level=clr_level=0 throughout; after release, FSM is IDLE and no pulse occurs with buttons low.
2. `btn_set` 0→1 and held → set_level=1 after edge 6; j=1 for exactly one cycle after edge 9; k stays 0; no further pulses while held or on release.
3. `btn_set` high for 3 cycles, then low → set_level never changes; j never pulses. Repeat with `btn_clr` → k never pulses.
4. `btn_set` rises at cycle 0 and `btn_clr` at cycle 1 → a single j=k=1 pulse after edge 8; no separate j or k pulse.
5. `btn_set` at cycle 0, `btn_clr` at cycle 3 → j alone after edge 9, then k alone after edge 12.
6. `btn_set` rises; `reset` pulsed low between edges 7 and 9 → no j pulse; with `btn_set` still high, j pulses once 9 edges after reset release.

Source files
------------

// File: rtl/jk_cmd_conditioner_if.sv
// Button-side and command-side signal bundle of the JK command conditioner.
// The master drives the raw buttons; the slave (the conditioner) returns commands and levels.
interface jk_cmd_conditioner_if;
    logic btn_set;
    logic btn_clr;
    logic j;
    logic k;
    logic set_level;
    logic clr_level;

    modport master (
        output btn_set,
        output btn_clr,
        input  j,
        input  k,
        input  set_level,
        input  clr_level
    );

    modport slave (
        input  btn_set,
        input  btn_clr,
        output j,
        output k,
        output set_level,
        output clr_level
    );
endinterface

// File: rtl/jk_cmd_conditioner.sv
// Synchronises and debounces two push buttons and turns their rising edges into
// one-cycle J/K commands, merging near-simultaneous presses into a toggle (J=K=1).
module jk_cmd_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3,
    parameter int PAIR_WINDOW     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    jk_cmd_conditioner_if.slave  bus
);
    // PAIR_WINDOW < 2*DEBOUNCE_CYCLES <= 2^(CNT_W+1), so one extra bit always suffices.
    localparam int WIN_W = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND_J = 2'd1,
        ST_PEND_K = 2'd2
    } state_t;

    // Channel 0 is set, channel 1 is clear throughout.
    logic [1:0]       btn_raw_s;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       lvl_q;
    logic [1:0]       lvl_d;
    logic [1:0]       lvl_dly_q;
    logic [1:0]       rise_s;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    state_t           state_q;
    state_t           state_d;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] win_d;
    logic             j_q;
    logic             j_d;
    logic             k_q;
    logic             k_d;

    assign btn_raw_s = {bus.btn_clr, bus.btn_set};

    // Two-flop synchroniser chain per channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= btn_raw_s;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next state: the level follows s2 only after it has differed for the full count.
    always_comb begin
        lvl_d = lvl_q;
        for (int ch = 0; ch < 2; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            if (sync2_q[ch] == lvl_q[ch]) begin
                cnt_d[ch] = {CNT_W{1'b0}};
            end else if (cnt_q[ch] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                lvl_d[ch] = sync2_q[ch];
                cnt_d[ch] = {CNT_W{1'b0}};
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
    end

    // Debounced level, its delayed copy for edge detection, and the debounce counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvl_q     <= 2'b00;
            lvl_dly_q <= 2'b00;
            cnt_q[0]  <= {CNT_W{1'b0}};
            cnt_q[1]  <= {CNT_W{1'b0}};
        end else begin
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_q;
            cnt_q[0]  <= cnt_d[0];
            cnt_q[1]  <= cnt_d[1];
        end
    end

    assign rise_s = lvl_q & ~lvl_dly_q;

    // Pairing FSM: a lone rise waits up to PAIR_WINDOW cycles for the other channel.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        j_d     = 1'b0;
        k_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_s[0] && rise_s[1]) begin
                    j_d = 1'b1;
                    k_d = 1'b1;
                end else if (rise_s[0]) begin
                    state_d = ST_PEND_J;
                    win_d   = {WIN_W{1'b0}};
                end else if (rise_s[1]) begin
                    state_d = ST_PEND_K;
                    win_d   = {WIN_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND_J: begin
                if (rise_s[1]) begin
                    j_d     = 1'b1;
                    k_d     = 1'b1;
                    state_d = ST_IDLE;
                end else if (win_q == WIN_W'(PAIR_WINDOW - 1)) begin
                    j_d     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    win_d = win_q + WIN_W'(1);
                end
            end
            ST_PEND_K: begin
                if (rise_s[0]) begin
                    j_d     = 1'b1;
                    k_d     = 1'b1;
                    state_d = ST_IDLE;
                end else if (win_q == WIN_W'(PAIR_WINDOW - 1)) begin
                    k_d     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    win_d = win_q + WIN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                win_d   = {WIN_W{1'b0}};
            end
        endcase
    end

    // FSM state, window counter and registered command pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            win_q   <= {WIN_W{1'b0}};
            j_q     <= 1'b0;
            k_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    assign bus.j         = j_q;
    assign bus.k         = k_q;
    assign bus.set_level = lvl_q[0];
    assign bus.clr_level = lvl_q[1];
endmodule

// File: tb/tb_jk_cmd_conditioner.sv
// Bench for jk_cmd_conditioner: directed scenarios plus random button traffic checked
// against a sliding-window debounce and interval-based pairing reference model.
module tb_jk_cmd_conditioner;
    localparam int D    = 4;
    localparam int PW   = 2;
    localparam int MAXN = 512;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    jk_cmd_conditioner_if bus ();

    jk_cmd_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3),
        .PAIR_WINDOW     (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // raw_x[e] is the button level sampled at rising edge e; index 0 is the reset state.
    bit   raw_s [MAXN];
    bit   raw_c [MAXN];
    bit   exp_j [MAXN];
    bit   exp_k [MAXN];
    bit   exp_sl[MAXN];
    bit   exp_cl[MAXN];
    bit   rs    [MAXN];
    bit   rc    [MAXN];
    logic obs_j [MAXN];
    logic obs_k [MAXN];
    logic obs_sl[MAXN];
    logic obs_cl[MAXN];

    function automatic bit s2_at(input bit ch, input int m);
        if (m < 1) return 1'b0;
        return ch ? raw_c[m-1] : raw_s[m-1];
    endfunction

    // Level flips once s2 has disagreed with it for the last D sampled edges.
    function automatic bit next_lvl(input bit ch, input int e, input bit prev);
        if (e < D) return prev;
        for (int m = e - D; m <= e - 1; m++)
            if (s2_at(ch, m) == prev) return prev;
        return ~prev;
    endfunction

    function automatic void build_model(input int n);
        int  e;
        int  pb;
        bit  found;
        for (int i = 0; i < MAXN; i++) begin
            exp_j[i] = 1'b0; exp_k[i] = 1'b0; exp_sl[i] = 1'b0; exp_cl[i] = 1'b0;
            rs[i] = 1'b0; rc[i] = 1'b0;
        end
        raw_s[0] = 1'b0;
        raw_c[0] = 1'b0;
        for (int i = 1; i <= n; i++) begin
            exp_sl[i] = next_lvl(1'b0, i, exp_sl[i-1]);
            exp_cl[i] = next_lvl(1'b1, i, exp_cl[i-1]);
        end
        for (int i = 2; i <= n; i++) begin
            rs[i] = exp_sl[i-1] && !exp_sl[i-2];
            rc[i] = exp_cl[i-1] && !exp_cl[i-2];
        end
        // A command occupies an interval; rises inside it are either its partner or dropped.
        e = 1;
        while (e <= n) begin
            if (rs[e] && rc[e]) begin
                exp_j[e] = 1'b1; exp_k[e] = 1'b1;
                e = e + 1;
            end else if (rs[e] || rc[e]) begin
                found = 1'b0;
                pb    = 0;
                for (int b = e + 1; b <= e + PW; b++)
                    if (!found && (rs[e] ? rc[b] : rs[b])) begin
                        found = 1'b1;
                        pb    = b;
                    end
                if (found) begin
                    if (pb <= n) begin exp_j[pb] = 1'b1; exp_k[pb] = 1'b1; end
                    e = pb + 1;
                end else begin
                    if (e + PW <= n) begin
                        if (rs[e]) exp_j[e+PW] = 1'b1;
                        else       exp_k[e+PW] = 1'b1;
                    end
                    e = e + PW + 1;
                end
            end else begin
                e = e + 1;
            end
        end
    endfunction

    function automatic int count_high(input int sel, input int n);
        int c = 0;
        for (int e = 0; e <= n; e++)
            case (sel)
                0: c += (obs_j[e]  === 1'b1) ? 1 : 0;
                1: c += (obs_k[e]  === 1'b1) ? 1 : 0;
                2: c += (obs_sl[e] === 1'b1) ? 1 : 0;
                default: c += (obs_cl[e] === 1'b1) ? 1 : 0;
            endcase
        return c;
    endfunction

    function automatic int first_high(input int sel, input int n);
        for (int e = 0; e <= n; e++)
            case (sel)
                0: if (obs_j[e]  === 1'b1) return e;
                1: if (obs_k[e]  === 1'b1) return e;
                2: if (obs_sl[e] === 1'b1) return e;
                default: if (obs_cl[e] === 1'b1) return e;
            endcase
        return -1;
    endfunction

    function automatic void clear_stim();
        for (int i = 0; i < MAXN; i++) begin
            raw_s[i] = 1'b0;
            raw_c[i] = 1'b0;
        end
    endfunction

    function automatic void fill_chan(input bit ch, input int lo, input int hi, input int n);
        int e   = 1;
        bit lvl = 1'b0;
        int len;
        while (e <= n) begin
            len = $urandom_range(hi, lo);
            for (int i = 0; i < len && e <= n; i++) begin
                if (ch) raw_c[e] = lvl; else raw_s[e] = lvl;
                e++;
            end
            lvl = ~lvl;
        end
    endfunction

    task automatic apply_reset();
        reset       = 1'b0;
        bus.btn_set = 1'b0;
        bus.btn_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    // Drives raw_x[1..n] one edge at a time and records outputs after every edge.
    task automatic drive_and_capture(input int n);
        obs_j[0] = bus.j; obs_k[0] = bus.k; obs_sl[0] = bus.set_level; obs_cl[0] = bus.clr_level;
        for (int e = 1; e <= n; e++) begin
            bus.btn_set = raw_s[e];
            bus.btn_clr = raw_c[e];
            @(posedge clk);
            @(negedge clk);
            obs_j[e] = bus.j; obs_k[e] = bus.k; obs_sl[e] = bus.set_level; obs_cl[e] = bus.clr_level;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.btn_set = 1'($urandom_range(1, 0));
            bus.btn_clr = 1'($urandom_range(1, 0));
            @(negedge clk);
            checks++;
            if ({bus.j, bus.k, bus.set_level, bus.clr_level} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got jk/levels %b want 0000", i,
                         {bus.j, bus.k, bus.set_level, bus.clr_level});
            end
        end
        bus.btn_set = 1'b0;
        bus.btn_clr = 1'b0;
        reset = 1'b1;
        clear_stim();
        build_model(20);
        drive_and_capture(20);
        for (int e = 0; e <= 20; e++) begin
            checks++; if (obs_j[e]  !== exp_j[e])  begin errors++; $display("FAIL reset_idle j e%0d: got %b want %b", e, obs_j[e], exp_j[e]); end
            checks++; if (obs_k[e]  !== exp_k[e])  begin errors++; $display("FAIL reset_idle k e%0d: got %b want %b", e, obs_k[e], exp_k[e]); end
            checks++; if (obs_sl[e] !== exp_sl[e]) begin errors++; $display("FAIL reset_idle set_level e%0d: got %b want %b", e, obs_sl[e], exp_sl[e]); end
            checks++; if (obs_cl[e] !== exp_cl[e]) begin errors++; $display("FAIL reset_idle clr_level e%0d: got %b want %b", e, obs_cl[e], exp_cl[e]); end
        end
    endtask

    task automatic test_lone_set();
        apply_reset();
        clear_stim();
        for (int e = 1; e <= 19; e++) raw_s[e] = 1'b1;
        build_model(40);
        drive_and_capture(40);
        for (int e = 0; e <= 40; e++) begin
            checks++; if (obs_j[e]  !== exp_j[e])  begin errors++; $display("FAIL lone_set j e%0d: got %b want %b", e, obs_j[e], exp_j[e]); end
            checks++; if (obs_k[e]  !== exp_k[e])  begin errors++; $display("FAIL lone_set k e%0d: got %b want %b", e, obs_k[e], exp_k[e]); end
            checks++; if (obs_sl[e] !== exp_sl[e]) begin errors++; $display("FAIL lone_set set_level e%0d: got %b want %b", e, obs_sl[e], exp_sl[e]); end
        end
        checks++; if (first_high(2, 40) != 6) begin errors++; $display("FAIL lone_set level_edge: got %0d want 6", first_high(2, 40)); end
        checks++; if (first_high(0, 40) != 9) begin errors++; $display("FAIL lone_set j_edge: got %0d want 9", first_high(0, 40)); end
        checks++; if (count_high(0, 40) != 1) begin errors++; $display("FAIL lone_set j_count: got %0d want 1", count_high(0, 40)); end
        checks++; if (count_high(1, 40) != 0) begin errors++; $display("FAIL lone_set k_count: got %0d want 0", count_high(1, 40)); end
    endtask

    task automatic test_glitch();
        for (int ch = 0; ch < 2; ch++) begin
            apply_reset();
            clear_stim();
            for (int e = 1; e <= 3; e++)
                if (ch == 1) raw_c[e] = 1'b1; else raw_s[e] = 1'b1;
            drive_and_capture(20);
            checks++; if (count_high(2 + ch, 20) != 0) begin errors++; $display("FAIL glitch ch%0d level_count: got %0d want 0", ch, count_high(2 + ch, 20)); end
            checks++; if (count_high(ch, 20) != 0) begin errors++; $display("FAIL glitch ch%0d pulse_count: got %0d want 0", ch, count_high(ch, 20)); end
        end
    endtask

    task automatic test_pair();
        apply_reset();
        clear_stim();
        for (int e = 1; e <= 30; e++) raw_s[e] = 1'b1;
        for (int e = 2; e <= 30; e++) raw_c[e] = 1'b1;
        drive_and_capture(30);
        checks++; if (first_high(0, 30) != 8) begin errors++; $display("FAIL pair j_edge: got %0d want 8", first_high(0, 30)); end
        checks++; if (first_high(1, 30) != 8) begin errors++; $display("FAIL pair k_edge: got %0d want 8", first_high(1, 30)); end
        checks++; if (count_high(0, 30) != 1) begin errors++; $display("FAIL pair j_count: got %0d want 1", count_high(0, 30)); end
        checks++; if (count_high(1, 30) != 1) begin errors++; $display("FAIL pair k_count: got %0d want 1", count_high(1, 30)); end
    endtask

    task automatic test_staggered();
        apply_reset();
        clear_stim();
        for (int e = 1; e <= 30; e++) raw_s[e] = 1'b1;
        for (int e = 4; e <= 30; e++) raw_c[e] = 1'b1;
        drive_and_capture(30);
        checks++; if (first_high(0, 30) != 9)  begin errors++; $display("FAIL stagger j_edge: got %0d want 9", first_high(0, 30)); end
        checks++; if (first_high(1, 30) != 12) begin errors++; $display("FAIL stagger k_edge: got %0d want 12", first_high(1, 30)); end
        checks++; if (count_high(0, 30) != 1)  begin errors++; $display("FAIL stagger j_count: got %0d want 1", count_high(0, 30)); end
        checks++; if (count_high(1, 30) != 1)  begin errors++; $display("FAIL stagger k_count: got %0d want 1", count_high(1, 30)); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        clear_stim();
        for (int e = 1; e <= 7; e++) raw_s[e] = 1'b1;
        drive_and_capture(7);
        checks++; if (obs_sl[7] !== 1'b1) begin errors++; $display("FAIL reset_mid level_before: got %b want 1", obs_sl[7]); end
        checks++; if (count_high(0, 7) != 0) begin errors++; $display("FAIL reset_mid early_j: got %0d want 0", count_high(0, 7)); end
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.j, bus.k, bus.set_level, bus.clr_level} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid async_clear: got %b want 0000", {bus.j, bus.k, bus.set_level, bus.clr_level});
        end
        @(negedge clk);
        checks++; if (bus.j !== 1'b0) begin errors++; $display("FAIL reset_mid j_in_reset: got %b want 0", bus.j); end
        reset = 1'b1;
        clear_stim();
        for (int e = 1; e <= 20; e++) raw_s[e] = 1'b1;
        build_model(20);
        drive_and_capture(20);
        for (int e = 0; e <= 20; e++) begin
            checks++; if (obs_j[e]  !== exp_j[e])  begin errors++; $display("FAIL reset_mid j e%0d: got %b want %b", e, obs_j[e], exp_j[e]); end
            checks++; if (obs_sl[e] !== exp_sl[e]) begin errors++; $display("FAIL reset_mid set_level e%0d: got %b want %b", e, obs_sl[e], exp_sl[e]); end
        end
        checks++; if (first_high(0, 20) != 9) begin errors++; $display("FAIL reset_mid j_edge: got %0d want 9", first_high(0, 20)); end
        checks++; if (count_high(0, 20) != 1) begin errors++; $display("FAIL reset_mid j_count: got %0d want 1", count_high(0, 20)); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        clear_stim();
        for (int e = 1; e <= 120; e++) raw_s[e] = (((e - 1) / 6) % 2) == 0;
        for (int e = 1; e <= 120; e++) raw_c[e] = (((e + 2) / 6) % 2) == 0;
        build_model(120);
        drive_and_capture(120);
        for (int e = 0; e <= 120; e++) begin
            checks++; if (obs_j[e]  !== exp_j[e])  begin errors++; $display("FAIL b2b j e%0d: got %b want %b", e, obs_j[e], exp_j[e]); end
            checks++; if (obs_k[e]  !== exp_k[e])  begin errors++; $display("FAIL b2b k e%0d: got %b want %b", e, obs_k[e], exp_k[e]); end
            checks++; if (obs_sl[e] !== exp_sl[e]) begin errors++; $display("FAIL b2b set_level e%0d: got %b want %b", e, obs_sl[e], exp_sl[e]); end
            checks++; if (obs_cl[e] !== exp_cl[e]) begin errors++; $display("FAIL b2b clr_level e%0d: got %b want %b", e, obs_cl[e], exp_cl[e]); end
        end
    endtask

    task automatic test_random(input int mode);
        int n = 300;
        int e;
        int gap, off, hold, start;
        bit lead;
        apply_reset();
        clear_stim();
        case (mode)
            0: begin fill_chan(1'b0, 1, 12, n); fill_chan(1'b1, 1, 12, n); end
            1: begin
                e = 1;
                while (e <= n - 40) begin
                    gap   = $urandom_range(20, 10);
                    off   = $urandom_range(4, 0);
                    hold  = $urandom_range(15, 8);
                    lead  = 1'($urandom_range(1, 0));
                    start = e + gap;
                    for (int i = 0; i < hold; i++) begin
                        if (lead) begin raw_c[start+i] = 1'b1; raw_s[start+off+i] = 1'b1; end
                        else      begin raw_s[start+i] = 1'b1; raw_c[start+off+i] = 1'b1; end
                    end
                    e = start + off + hold;
                end
            end
            default: begin fill_chan(1'b0, 1, 6, n); fill_chan(1'b1, 2, 7, n); end
        endcase
        build_model(n);
        drive_and_capture(n);
        for (int i = 0; i <= n; i++) begin
            checks++; if (obs_j[i]  !== exp_j[i])  begin errors++; $display("FAIL random%0d j e%0d: got %b want %b", mode, i, obs_j[i], exp_j[i]); end
            checks++; if (obs_k[i]  !== exp_k[i])  begin errors++; $display("FAIL random%0d k e%0d: got %b want %b", mode, i, obs_k[i], exp_k[i]); end
            checks++; if (obs_sl[i] !== exp_sl[i]) begin errors++; $display("FAIL random%0d set_level e%0d: got %b want %b", mode, i, obs_sl[i], exp_sl[i]); end
            checks++; if (obs_cl[i] !== exp_cl[i]) begin errors++; $display("FAIL random%0d clr_level e%0d: got %b want %b", mode, i, obs_cl[i], exp_cl[i]); end
        end
    endtask

    initial begin
        bus.btn_set = 1'b0;
        bus.btn_clr = 1'b0;
        test_reset();
        test_lone_set();
        test_glitch();
        test_pair();
        test_staggered();
        test_reset_mid();
        test_back_to_back();
        test_random(0);
        test_random(1);
        test_random(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
